operand_read_stage: RTL
=======================

Name: operand_read_stage

Overview:
- Register-read (RR) pipeline stage directly downstream of the 8 x 16-bit register bank; sits between decode and execute.
- Drives the bank's two read addresses and consumes its combinational read data.
- Resolves RAW hazards by forwarding from EX, MEM and WB, substitutes the PC for R7 reads, and stalls on load-use.
- Registers the resolved operands into the RR/EX pipeline register.

Parameters:
- DATA_W, 16, operand/data width
- ADDR_W, 3, register address width
- PC_REG, 7, index of the PC-mapped register

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode slot holds a real instruction
- in_ra, in_rb  in  ADDR_W  source register addresses
- in_use_ra, in_use_rb  in  1  source actually read by the instruction
- in_rd  in  ADDR_W  destination address, passed through
- in_rd_we  in  1  instruction writes rd, passed through
- in_is_load  in  1  instruction is a load, passed through
- in_pc  in  DATA_W  PC of this instruction
- flush  in  1  squash current and next RR contents (branch mispredict)
- rf_radd1, rf_radd2  out  ADDR_W  to bank read ports (= in_ra, in_rb, combinational)
- rf_rdata1, rf_rdata2  in  DATA_W  bank read data
- ex_we, ex_is_load  in  1  EX-stage write enable / load flag
- ex_wa  in  ADDR_W  EX-stage destination
- ex_wd  in  DATA_W  EX-stage result
- mem_we  in  1  MEM-stage write enable
- mem_wa  in  ADDR_W  MEM-stage destination
- mem_wd  in  DATA_W  MEM-stage result
- wb_we  in  1  WB-stage write enable
- wb_wa  in  ADDR_W  WB-stage destination
- wb_wd  in  DATA_W  WB-stage result
- stall  out  1  hold decode/fetch this cycle (combinational)
- out_valid  out  1  RR/EX register valid
- out_opa, out_opb  out  DATA_W  resolved operands
- out_rd  out  ADDR_W  registered rd
- out_rd_we, out_is_load  out  1  registered control
- out_pc  out  DATA_W  registered PC
- stall_count  out  16  stall statistics (see Optional Feature)

Behaviour:
- Clocking: clk. reset is synchronous, active-high. On reset, all outputs registered by this stage clear to 0: out_valid, out_opa, out_opb, out_rd, out_rd_we, out_is_load, out_pc, stall_count.
- Operand resolution is combinational, per source (a, b), first match wins:
  1. Address == PC_REG -> in_pc. Never forwarded; writes to PC_REG on any forwarding bus are ignored.
  2. ex_we && ex_wa == addr && !ex_is_load -> ex_wd.
  3. mem_we && mem_wa == addr -> mem_wd.
  4. wb_we && wb_wa == addr -> wb_wd. Required because the bank writes on the same edge.
  5. Otherwise -> rf_rdata.
- Load-use hazard: stall = in_valid && !flush && ex_we && ex_is_load && ex_wa != PC_REG && ((in_use_ra && in_ra == ex_wa) || (in_use_rb && in_rb == ex_wa)).
- Unused sources (in_use_x = 0) never cause a stall; their operand is still resolved.
- Pipeline register update, priority reset > flush > stall > normal:
  - flush: out_valid <= 0; other fields don't-care, implemented as hold.
  - stall: out_valid <= 0 (bubble). Upstream holds its inputs; the instruction is re-evaluated next cycle, when the load is in MEM and is forwarded from mem_wd.
  - normal: out_* <= resolved values; out_valid <= in_valid.
- Latency: 1 cycle from the decode slot to out_*. Stall costs exactly 1 bubble per load-use pair.
- in_valid = 0: no stall is asserted; a bubble propagates.
- Flush and stall in the same cycle: flush wins; stall is forced low.
- Reset mid-stall: stall is released on the next cycle, since out_valid is 0.

Optional Feature:
- Macro: OPERAND_READ_STALL_COUNT_EN.
- Defined: stall_count is a 16-bit counter, incremented on each cycle with stall = 1, saturating at 16'hFFFF, cleared by reset.
- Undefined: stall_count is tied to 0; no counter logic is generated.

Decomposition:
- Shared package riscp_pkg holds:
  - DATA_W, ADDR_W and PC_REG constants.
  - Forward-select enum fwd_sel_t: FWD_RF, FWD_EX, FWD_MEM, FWD_WB, FWD_PC.
- Sub-module operand_fwd_mux: one source's priority select plus its hazard match. Instantiated twice, for a and b.

Test Plan:
- Reset, then in_ra=3 with bank R3=16'h0003 and no writers -> next cycle out_opa=16'h0003, out_valid=1, stall_count=0.
- EX writes R2=16'h00AA (non-load); MEM writes R2=16'h00BB; in_ra=2 -> out_opa=16'h00AA (EX priority over MEM).
- EX load to R4 and in_rb=4, in_use_rb=1 -> stall=1 for 1 cycle and a bubble (out_valid=0). Next cycle the load is in MEM with mem_wd=16'h1234 -> out_opb=16'h1234, stall_count=1 (macro on).
- in_ra=7, in_pc=16'h0040, EX writing R7=16'hFFFF -> out_opa=16'h0040, no stall.
- WB writes R5=16'h0055 while bank still returns 0 -> out_opa=16'h0055. Same load-use as above but with in_use_rb=0 -> no stall.
- flush asserted together with a load-use condition -> stall=0, out_valid=0 next cycle. Assert reset during a stall -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/riscp_pkg.sv
// riscp_pkg
// Shared constants and types for the register-read stage and its operand
// forwarding muxes.
//   DATA_W    operand/data width
//   ADDR_W    register address width
//   PC_REG    register index that reads as the instruction's PC
//   fwd_sel_t source picked for one operand
package riscp_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam logic [ADDR_W-1:0] PC_REG = 3'd7;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_PC
    } fwd_sel_t;

endpackage

// File: rtl/operand_read_stage_if.sv
// operand_read_stage_if
// Read-port bundle between the register-read stage and the 8 x 16 register
// bank. The bank read is combinational: data follows the addresses in the
// same cycle.
//   rf_radd1/rf_radd2    read addresses (stage -> bank)
//   rf_rdata1/rf_rdata2  read data      (bank -> stage)
// Modports: master = register-read stage, slave = register bank.
interface operand_read_stage_if;
    import riscp_pkg::*;

    logic [ADDR_W-1:0] rf_radd1;
    logic [ADDR_W-1:0] rf_radd2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    modport master (
        output rf_radd1, rf_radd2,
        input  rf_rdata1, rf_rdata2
    );

    modport slave (
        input  rf_radd1, rf_radd2,
        output rf_rdata1, rf_rdata2
    );

endinterface

// File: rtl/operand_read_stage_fwd_mux.sv
// operand_fwd_mux
// Resolves one source operand: PC substitution, then forwarding from EX,
// MEM and WB (youngest first), else bank data. Also flags a load-use match
// against the EX stage for this source.
//   addr, useSrc            source address and whether it is really read
//   pc, rfData              instruction PC and bank read data
//   ex*/mem*/wb*            forwarding buses
//   operand                 resolved value
//   loadHazard              this source depends on a load still in EX
module operand_fwd_mux
    import riscp_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic              useSrc,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rfData,
    input  logic              exWe,
    input  logic              exIsLoad,
    input  logic [ADDR_W-1:0] exWa,
    input  logic [DATA_W-1:0] exWd,
    input  logic              memWe,
    input  logic [ADDR_W-1:0] memWa,
    input  logic [DATA_W-1:0] memWd,
    input  logic              wbWe,
    input  logic [ADDR_W-1:0] wbWa,
    input  logic [DATA_W-1:0] wbWd,
    output logic [DATA_W-1:0] operand,
    output logic              loadHazard
);

    fwd_sel_t sel;

    // PC check comes first so writes aimed at the PC index are never forwarded.
    // A load in EX has no data yet, so it is skipped here and caught by the stall.
    always_comb begin
        sel = FWD_RF;
        if (addr == PC_REG)
            sel = FWD_PC;
        else if (exWe && (exWa == addr) && !exIsLoad)
            sel = FWD_EX;
        else if (memWe && (memWa == addr))
            sel = FWD_MEM;
        else if (wbWe && (wbWa == addr))
            sel = FWD_WB;
    end

    always_comb begin
        operand = rfData;
        case (sel)
            FWD_PC:  operand = pc;
            FWD_EX:  operand = exWd;
            FWD_MEM: operand = memWd;
            FWD_WB:  operand = wbWd;
            default: operand = rfData;
        endcase
    end

    assign loadHazard = useSrc && exWe && exIsLoad &&
                        (exWa != PC_REG) && (exWa == addr);

endmodule

// File: rtl/operand_read_stage.sv
// operand_read_stage
// Register-read pipeline stage between decode and execute. Drives the bank
// read addresses, resolves both operands (PC substitution + EX/MEM/WB
// forwarding), stalls decode for one cycle on a load-use dependency and
// registers the result into the RR/EX register.
//   clk, reset (synchronous, active-high)
//   in_*            decode slot contents
//   flush           squash the slot (branch mispredict)
//   rf              register bank read port (master side)
//   ex_*/mem_*/wb_* forwarding buses
//   stall           hold decode/fetch this cycle (combinational)
//   out_*           RR/EX register
//   stall_count     stall statistics
// Build option: OPERAND_READ_STALL_COUNT_EN enables a saturating stall
// counter on stall_count; without it stall_count is constant 0.
module operand_read_stage
    import riscp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_ra,
    input  logic [ADDR_W-1:0] in_rb,
    input  logic              in_use_ra,
    input  logic              in_use_rb,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    operand_read_stage_if.master rf,
    input  logic              ex_we,
    input  logic              ex_is_load,
    input  logic [ADDR_W-1:0] ex_wa,
    input  logic [DATA_W-1:0] ex_wd,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_wa,
    input  logic [DATA_W-1:0] mem_wd,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_wa,
    input  logic [DATA_W-1:0] wb_wd,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [DATA_W-1:0] out_pc,
    output logic [15:0]       stall_count
);

    logic [DATA_W-1:0] opaRes;
    logic [DATA_W-1:0] opbRes;
    logic              hazA;
    logic              hazB;

    assign rf.rf_radd1 = in_ra;
    assign rf.rf_radd2 = in_rb;

    operand_fwd_mux muxA (
        .addr       (in_ra),
        .useSrc     (in_use_ra),
        .pc         (in_pc),
        .rfData     (rf.rf_rdata1),
        .exWe       (ex_we),
        .exIsLoad   (ex_is_load),
        .exWa       (ex_wa),
        .exWd       (ex_wd),
        .memWe      (mem_we),
        .memWa      (mem_wa),
        .memWd      (mem_wd),
        .wbWe       (wb_we),
        .wbWa       (wb_wa),
        .wbWd       (wb_wd),
        .operand    (opaRes),
        .loadHazard (hazA)
    );

    operand_fwd_mux muxB (
        .addr       (in_rb),
        .useSrc     (in_use_rb),
        .pc         (in_pc),
        .rfData     (rf.rf_rdata2),
        .exWe       (ex_we),
        .exIsLoad   (ex_is_load),
        .exWa       (ex_wa),
        .exWd       (ex_wd),
        .memWe      (mem_we),
        .memWa      (mem_wa),
        .memWd      (mem_wd),
        .wbWe       (wb_we),
        .wbWa       (wb_wa),
        .wbWd       (wb_wd),
        .operand    (opbRes),
        .loadHazard (hazB)
    );

    // A flushed slot is dead anyway, so it must not hold decode.
    assign stall = in_valid && !flush && (hazA || hazB);

    // Flush and stall both insert a bubble; payload fields simply hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_opa     <= '0;
            out_opb     <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_is_load <= 1'b0;
            out_pc      <= '0;
        end else if (flush || stall) begin
            out_valid <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            out_opa     <= opaRes;
            out_opb     <= opbRes;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
            out_is_load <= in_is_load;
            out_pc      <= in_pc;
        end
    end

`ifdef OPERAND_READ_STALL_COUNT_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk) begin
        if (reset)
            stallCnt <= '0;
        else if (stall && (stallCnt != 16'hFFFF))
            stallCnt <= stallCnt + 16'd1;
    end

    assign stall_count = stallCnt;
`else
    assign stall_count = '0;
`endif

endmodule
